// File: rtl/gpu_pkg.sv
// Shared GPU core definitions.
//   warp_arb_state_t : warp arbiter FSM states
//   MAX_WARPS        : largest warp count a core may be built with
package gpu_pkg;

  localparam int MAX_WARPS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    DONE  = 2'd3
  } warp_arb_state_t;

endpackage

// File: rtl/warp_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
// Searches last+1, last+2, ... (mod NUM_WARPS) and returns the first set request.
//   req      : request vector
//   last     : index granted most recently
//   pick     : one-hot of the chosen index (zero when nothing requested)
//   pick_idx : binary index of the chosen request
//   any      : at least one request was set
module rr_picker
  import gpu_pkg::*;
#(
  parameter int NUM_WARPS = 2,
  localparam int IW = $clog2(NUM_WARPS)
) (
  input  logic [NUM_WARPS-1:0] req,
  input  logic [IW-1:0]        last,
  output logic [NUM_WARPS-1:0] pick,
  output logic [IW-1:0]        pick_idx,
  output logic                 any
);

  logic [IW-1:0] cand;

  function automatic int wrap_idx(input int v);
    return (v >= NUM_WARPS) ? v - NUM_WARPS : v;
  endfunction

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = '0;
    // k runs to NUM_WARPS so that 'last' itself is the lowest-priority candidate.
    for (int k = 1; k <= NUM_WARPS; k++) begin
      cand = IW'(wrap_idx(int'(last) + k));
      if (!any && req[cand]) begin
        any        = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/warp_arbiter.sv
// warp_arbiter: round-robin owner of the core's single decode/ALU issue slot.
//   clk, reset     : core clock, asynchronous active-high reset
//   kernel_start   : start pulse, accepted only in IDLE or DONE
//   warp_enable    : warps holding threads, captured on an accepted start
//   warp_req       : level request for the issue slot
//   warp_release   : grantee gives up the slot (ignored from other warps)
//   warp_ret       : warp retired; never granted again until the next start
//   grant          : one-hot slot owner, zero when unowned
//   grant_valid    : OR of grant
//   warp_select    : index of the latest grantee (holds while unowned)
//   done           : every enabled warp has retired
//   stall_count    : saturating count of cycles a waiting warp was denied
module warp_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_WARPS      = 2,
  parameter int STALL_CNT_BITS = 16,
  localparam int IW = $clog2(NUM_WARPS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      kernel_start,
  input  logic [NUM_WARPS-1:0]      warp_enable,
  input  logic [NUM_WARPS-1:0]      warp_req,
  input  logic [NUM_WARPS-1:0]      warp_release,
  input  logic [NUM_WARPS-1:0]      warp_ret,
  output logic [NUM_WARPS-1:0]      grant,
  output logic                      grant_valid,
  output logic [IW-1:0]             warp_select,
  output logic                      done,
  output logic [STALL_CNT_BITS-1:0] stall_count
);

  if (NUM_WARPS < 2 || NUM_WARPS > MAX_WARPS) begin : g_bad_num_warps
    $error("warp_arbiter: NUM_WARPS out of range");
  end

  warp_arb_state_t           state, state_nxt;
  logic [NUM_WARPS-1:0]      active, active_nxt;
  logic [NUM_WARPS-1:0]      retired, retired_nxt;
  logic [NUM_WARPS-1:0]      grant_nxt;
  logic [IW-1:0]             last, last_nxt;
  logic [IW-1:0]             sel_nxt;
  logic [STALL_CNT_BITS-1:0] stall_nxt;

  logic [NUM_WARPS-1:0]      eligible;
  logic [NUM_WARPS-1:0]      pick;
  logic [IW-1:0]             pick_idx;
  logic                      pick_any;
  logic                      running;

  function automatic logic [STALL_CNT_BITS-1:0] sat_inc(input logic [STALL_CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign eligible    = warp_req & active & ~retired;
  assign running     = (state == ARB) || (state == GRANT);
  assign grant_valid = |grant;
  assign done        = (state == DONE);

  rr_picker #(
    .NUM_WARPS (NUM_WARPS)
  ) u_picker (
    .req      (eligible),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_nxt   = state;
    active_nxt  = active;
    retired_nxt = retired;
    grant_nxt   = grant;
    sel_nxt     = warp_select;
    last_nxt    = last;
    stall_nxt   = stall_count;

    if (state != IDLE) begin
      retired_nxt = retired | warp_ret;
    end

    // In ARB grant is zero, so any eligible warp counts as stalled.
    if (running && |(eligible & ~grant)) begin
      stall_nxt = sat_inc(stall_count);
    end

    case (state)
      IDLE, DONE: begin
        if (kernel_start) begin
          active_nxt  = warp_enable;
          retired_nxt = '0;
          stall_nxt   = '0;
          state_nxt   = (warp_enable == '0) ? DONE : ARB;
        end
      end
      ARB: begin
        if ((active & ~retired) == '0) begin
          state_nxt = DONE;
        end else if (pick_any) begin
          grant_nxt = pick;
          sel_nxt   = pick_idx;
          last_nxt  = pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // warp_select names the grantee while in GRANT.
        if (warp_release[warp_select] || warp_ret[warp_select]) begin
          grant_nxt = '0;
          state_nxt = ARB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      active      <= '0;
      retired     <= '0;
      grant       <= '0;
      warp_select <= '0;
      last        <= IW'(NUM_WARPS - 1);
      stall_count <= '0;
    end else begin
      state       <= state_nxt;
      active      <= active_nxt;
      retired     <= retired_nxt;
      grant       <= grant_nxt;
      warp_select <= sel_nxt;
      last        <= last_nxt;
      stall_count <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_warp_arbiter.sv
module tb_warp_arbiter;

  localparam int N  = 3;
  localparam int SB = 4;
  localparam int IW = $clog2(N);
  localparam int STALL_MAX = (1 << SB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          kernel_start;
  logic [N-1:0]  warp_enable, warp_req, warp_release, warp_ret;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] warp_select;
  logic          done;
  logic [SB-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  warp_arbiter #(.NUM_WARPS(N), .STALL_CNT_BITS(SB)) dut (
    .clk          (clk),
    .reset        (reset),
    .kernel_start (kernel_start),
    .warp_enable  (warp_enable),
    .warp_req     (warp_req),
    .warp_release (warp_release),
    .warp_ret     (warp_ret),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .warp_select  (warp_select),
    .done         (done),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the slot, whether a kernel is running/finished,
  // which warps are enabled/retired, the round-robin pointer and the stall tally.
  int       m_owner;
  bit       m_started, m_fin;
  bit [N-1:0] m_act, m_ret;
  int       m_last, m_sel, m_stall;

  always @(posedge clk or posedge reset) begin
    bit [N-1:0] elig;
    bit waiting, run, found;
    int idx;
    if (reset) begin
      m_owner = -1; m_started = 0; m_fin = 0; m_act = '0; m_ret = '0;
      m_last = N - 1; m_sel = 0; m_stall = 0;
    end else begin
      elig = warp_req & m_act & ~m_ret;
      run  = m_started && !m_fin;
      waiting = 0;
      for (int i = 0; i < N; i++) if (elig[i] && i != m_owner) waiting = 1;
      if (kernel_start && (!m_started || m_fin)) begin
        m_started = 1; m_act = warp_enable; m_ret = '0; m_stall = 0;
        m_fin = (warp_enable == '0); m_owner = -1;
      end else begin
        if (run && waiting && m_stall < STALL_MAX) m_stall++;
        if (run && m_owner < 0) begin
          if ((m_act & ~m_ret) == '0) m_fin = 1;
          else begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
              idx = (m_last + k) % N;
              if (!found && elig[idx]) begin
                found = 1; m_owner = idx; m_last = idx; m_sel = idx;
              end
            end
          end
        end else if (run) begin
          if (warp_release[m_owner] || warp_ret[m_owner]) m_owner = -1;
        end
        if (m_started) m_ret |= warp_ret;
      end
    end
  end

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_grant", grant, exp_grant());
      chk("model_grant_valid", grant_valid, m_owner >= 0);
      chk("model_warp_select", warp_select, m_sel);
      chk("model_done", done, m_fin);
      chk("model_stall", stall_count, m_stall);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; kernel_start = 0;
    warp_enable = '0; warp_req = '0; warp_release = '0; warp_ret = '0;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_valid", grant_valid, 0);
    chk("rst_sel", warp_select, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_count, 0);
    reset = 1'b0;

    // Basic handoff and stall counting
    warp_enable = 3'b011; kernel_start = 1; tick();
    kernel_start = 0; warp_req = 3'b001; tick();
    chk("first_grant", grant, 3'b001);
    chk("first_sel", warp_select, 0);
    chk("stall_arb", stall_count, 1);
    warp_req = 3'b011;
    repeat (5) tick();
    chk("stall_hold5", stall_count, 6);
    chk("hold_grant", grant, 3'b001);
    warp_release = 3'b001; tick();
    warp_release = '0;
    chk("bubble_grant", grant, 3'b000);
    chk("bubble_valid", grant_valid, 0);
    tick();
    chk("handoff_grant", grant, 3'b010);
    chk("handoff_sel", warp_select, 1);
    warp_release = 3'b010; tick();
    warp_release = '0;
    chk("bubble2_grant", grant, 3'b000);
    tick();
    chk("back_grant", grant, 3'b001);
    chk("back_stall", stall_count, 10);

    // Retire while granted
    warp_ret = 3'b001; tick();
    warp_ret = '0;
    chk("ret_drop", grant, 3'b000);
    tick();
    chk("ret_other", grant, 3'b010);
    warp_ret = 3'b010; tick();
    warp_ret = '0;
    chk("last_ret_done0", done, 0);
    tick();
    chk("last_ret_done1", done, 1);
    chk("last_ret_grant", grant, 0);
    warp_enable = 3'b011; kernel_start = 1; warp_req = '0; tick();
    kernel_start = 0;
    chk("restart_done", done, 0);
    chk("restart_stall", stall_count, 0);
    warp_ret = 3'b011; tick();
    warp_ret = '0; tick();
    chk("finish_done", done, 1);

    // Partial enable
    warp_enable = 3'b001; kernel_start = 1; warp_req = 3'b010; tick();
    kernel_start = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("partial_nogrant", grant, 0);
    end
    warp_ret = 3'b001; tick();
    warp_ret = '0;
    chk("partial_done0", done, 0);
    tick();
    chk("partial_done1", done, 1);

    // Empty kernel
    warp_enable = '0; kernel_start = 1; warp_req = 3'b111; tick();
    kernel_start = 0;
    chk("empty_done", done, 1);
    chk("empty_grant", grant, 0);
    tick();
    chk("empty_grant2", grant, 0);

    // Async reset mid-grant; pointer must return to its reset value
    warp_enable = 3'b111; kernel_start = 1; warp_req = 3'b010; tick();
    kernel_start = 0; tick();
    chk("pre_reset_grant", grant, 3'b010);
    #3 reset = 1'b1;
    #1;
    chk("async_grant", grant, 0);
    chk("async_valid", grant_valid, 0);
    chk("async_sel", warp_select, 0);
    chk("async_stall", stall_count, 0);
    tick();
    reset = 1'b0;
    warp_enable = 3'b111; kernel_start = 1; warp_req = 3'b111; tick();
    kernel_start = 0; tick();
    chk("post_reset_grant", grant, 3'b001);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset        = 1'b0;
      kernel_start = ($urandom_range(0, 15) == 0);
      warp_enable  = N'($urandom);
      warp_req     = N'($urandom);
      warp_release = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      warp_ret     = ($urandom_range(0, 9) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      if ($urandom_range(0, 400) == 0) begin
        #2 reset = 1'b1;
        #1;
        chk("rand_async_grant", grant, 0);
      end
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
